// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (640x480 @ 60 Hz by default) driven from a
// 50 MHz clock with a 25 MHz pixel tick enable.
//
// Ports:
//   CLOCK_50            system clock, all logic on the rising edge
//   RESET_N             asynchronous active-low reset
//   PIX_R/PIX_G/PIX_B   renderer colour for the coordinate presented on the previous pixel tick
//   PIX_X/PIX_Y         registered horizontal/vertical counters
//   PIX_REQ             current (PIX_X, PIX_Y) lies in the visible area
//   PIX_CE              pixel tick enable, high every second CLOCK_50 cycle
//   FRAME_START         high in the tick where the counters are (0,0)
//   VGA_HS/VGA_VS       active-low syncs, two ticks behind the counters
//   VGA_R/VGA_G/VGA_B   colour, aligned with the syncs, forced to 0 outside the visible area
//   FRAME_CNT           16-bit frame counter, present only when VGA_FRAME_CNT_EN is defined
//
// Optional feature: define VGA_FRAME_CNT_EN to add the FRAME_CNT output.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [3:0]  PIX_R,
  input  logic [3:0]  PIX_G,
  input  logic [3:0]  PIX_B,
  output logic [9:0]  PIX_X,
  output logic [9:0]  PIX_Y,
  output logic        PIX_REQ,
  output logic        PIX_CE,
  output logic        FRAME_START,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] FRAME_CNT
`endif
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] HVis       = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncFirst = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] VVis       = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncFirst = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       ce_q, ce_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       visible;

  // Stage 1: decoded syncs and visibility for the tick just counted.
  logic       hs1_q, hs1_d;
  logic       vs1_q, vs1_d;
  logic       act1_q, act1_d;

  // Stage 2: output registers.
  logic       hs2_q, hs2_d;
  logic       vs2_q, vs2_d;
  logic [3:0] r2_q, r2_d;
  logic [3:0] g2_q, g2_d;
  logic [3:0] b2_q, b2_d;

  assign visible = (hcnt_q < HVis) && (vcnt_q < VVis);

  always_comb begin
    ce_d   = ~ce_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    hs1_d  = hs1_q;
    vs1_d  = vs1_q;
    act1_d = act1_q;
    hs2_d  = hs2_q;
    vs2_d  = vs2_q;
    r2_d   = r2_q;
    g2_d   = g2_q;
    b2_d   = b2_q;
    if (ce_q) begin
      if (hcnt_q == HLast) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
      hs1_d  = ~((hcnt_q >= HSyncFirst) && (hcnt_q <= HSyncLast));
      vs1_d  = ~((vcnt_q >= VSyncFirst) && (vcnt_q <= VSyncLast));
      act1_d = visible;
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      // PIX_R/G/B belong to the coordinate captured in stage 1 on the previous tick.
      r2_d   = act1_q ? PIX_R : 4'h0;
      g2_d   = act1_q ? PIX_G : 4'h0;
      b2_d   = act1_q ? PIX_B : 4'h0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ce_q   <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      act1_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      r2_q   <= '0;
      g2_q   <= '0;
      b2_q   <= '0;
    end else begin
      ce_q   <= ce_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      act1_q <= act1_d;
      hs2_q  <= hs2_d;
      vs2_q  <= vs2_d;
      r2_q   <= r2_d;
      g2_q   <= g2_d;
      b2_q   <= b2_d;
    end
  end

  assign PIX_X       = hcnt_q;
  assign PIX_Y       = vcnt_q;
  assign PIX_REQ     = visible;
  assign PIX_CE      = ce_q;
  assign FRAME_START = ce_q && (hcnt_q == '0) && (vcnt_q == '0);
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_R       = r2_q;
  assign VGA_G       = g2_q;
  assign VGA_B       = b2_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (FRAME_START) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a reduced raster (25 x 11) so whole frames fit in a short
// run. Expected outputs come from a position-based model: cycle c after reset release maps to
// raster position c/2, outputs show the position two ticks earlier.
module tb_vga_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 4;
  localparam int HBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pix_r = 4'h0;
  logic [3:0] pix_g = 4'h0;
  logic [3:0] pix_b = 4'h0;
  logic [9:0] pix_x, pix_y;
  logic       pix_req, pix_ce, frame_start, vga_hs, vga_vs;
  logic [3:0] vga_r, vga_g, vga_b;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  tab_r [FT];
  logic [3:0]  tab_g [FT];
  logic [3:0]  tab_b [FT];
  logic [11:0] pend = 12'h0;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        req;
    logic        ce;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .PIX_R      (pix_r),
    .PIX_G      (pix_g),
    .PIX_B      (pix_b),
    .PIX_X      (pix_x),
    .PIX_Y      (pix_y),
    .PIX_REQ    (pix_req),
    .PIX_CE     (pix_ce),
    .FRAME_START(frame_start),
    .VGA_HS     (vga_hs),
    .VGA_VS     (vga_vs),
    .VGA_R      (vga_r),
    .VGA_G      (vga_g),
    .VGA_B      (vga_b)
`ifdef VGA_FRAME_CNT_EN
    ,
    .FRAME_CNT  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Reference: position p = c/2 ticks since release; outputs reflect position p-2.
  function automatic exp_t model(input int c);
    exp_t e;
    int p, q, qx, qy;
    p     = c / 2;
    e.ce  = (c % 2) == 1;
    e.x   = 10'(p % HT);
    e.y   = 10'((p / HT) % VT);
    e.req = ((p % HT) < HA) && (((p / HT) % VT) < VA);
    e.fs  = e.ce && ((p % FT) == 0);
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    e.rgb = 12'h0;
    if (p >= 2) begin
      q    = (p - 2) % FT;
      qx   = q % HT;
      qy   = q / HT;
      e.hs = !(qx >= HA + HFP && qx < HA + HFP + HSW);
      e.vs = !(qy >= VA + VFP && qy < VA + VFP + VSW);
      if (qx < HA && qy < VA) e.rgb = {tab_r[q], tab_g[q], tab_b[q]};
    end
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = {pix_x, pix_y, pix_req, pix_ce, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b};
    return o;
  endfunction

  // mode 0: random, 1: red echoes x[3:0], 2: all 4'hF, 3: random non-zero
  task automatic fill_tab(input int mode);
    for (int i = 0; i < FT; i++) begin
      case (mode)
        1: begin tab_r[i] = 4'(i % HT); tab_g[i] = 4'h0; tab_b[i] = 4'h0; end
        2: begin tab_r[i] = 4'hF; tab_g[i] = 4'hF; tab_b[i] = 4'hF; end
        3: begin
          tab_r[i] = 4'($urandom_range(15, 1));
          tab_g[i] = 4'($urandom_range(15, 1));
          tab_b[i] = 4'($urandom_range(15, 1));
        end
        default: begin
          tab_r[i] = 4'($urandom); tab_g[i] = 4'($urandom); tab_b[i] = 4'($urandom);
        end
      endcase
    end
  endtask

  // One CLOCK_50 cycle; the renderer registers its colour on PIX_CE and presents it next tick.
  task automatic tick();
    int i;
    @(negedge clk);
    {pix_r, pix_g, pix_b} = pend;
    if (pix_ce && int'(pix_x) < HT && int'(pix_y) < VT) begin
      i    = int'(pix_y) * HT + int'(pix_x);
      pend = {tab_r[i], tab_g[i], tab_b[i]};
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend  = 12'h0;
    {pix_r, pix_g, pix_b} = 12'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (pix_x !== 10'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", pix_x); end
    n_tests++; if (pix_y !== 10'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", pix_y); end
    n_tests++; if (pix_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", pix_req); end
    n_tests++; if (pix_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b want 0", pix_ce); end
    n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    n_tests++; if (vga_hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b want 1", vga_hs); end
    n_tests++; if (vga_vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b want 1", vga_vs); end
    n_tests++;
    if ({vga_r, vga_g, vga_b} !== 12'h0) begin
      n_fail++; $display("FAIL reset_rgb: got %h want 000", {vga_r, vga_g, vga_b});
    end
`ifdef VGA_FRAME_CNT_EN
    n_tests++; if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_fcnt: got %h want 0000", frame_cnt); end
`endif
  endtask

  // Cycle-by-cycle comparison of every output against the model for n whole frames.
  task automatic test_frames(input int nframes, input int mode);
    exp_t e, o;
    do_reset();
    fill_tab(mode);
    release_reset();
    for (int c = 0; c < 2 * FT * nframes + 4; c++) begin
      if (c > 0) tick();
      e = model(c);
      o = observed();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL frame_m%0d c=%0d got x=%0d y=%0d req=%b ce=%b fs=%b hs=%b vs=%b rgb=%h want x=%0d y=%0d req=%b ce=%b fs=%b hs=%b vs=%b rgb=%h",
                 mode, c, o.x, o.y, o.req, o.ce, o.fs, o.hs, o.vs, o.rgb,
                 e.x, e.y, e.req, e.ce, e.fs, e.hs, e.vs, e.rgb);
      end
    end
  endtask

  task automatic test_sync();
    int prev_x, fall_ref, hs_run, vs_run, last_fs, last_wrap, n_hs_runs, n_vs_runs, ce_bad;
    logic prev_hs, prev_vs;
    do_reset();
    fill_tab(0);
    release_reset();
    prev_x = 0; fall_ref = -1; hs_run = 0; vs_run = 0; last_fs = -1; last_wrap = -1;
    n_hs_runs = 0; n_vs_runs = 0; ce_bad = 0; prev_hs = 1'b1; prev_vs = 1'b1;
    for (int c = 0; c < 4 * FT + 8; c++) begin
      if (c > 0) tick();
      if (pix_ce !== 1'((c % 2) == 1)) ce_bad++;
      if (int'(pix_x) == HA + HFP && prev_x != HA + HFP) fall_ref = c;
      if (int'(pix_x) == 0 && prev_x == HT - 1) begin
        if (last_wrap >= 0) begin
          n_tests++;
          if (c - last_wrap != 2 * HT) begin
            n_fail++; $display("FAIL line_period: got %0d want %0d", c - last_wrap, 2 * HT);
          end
        end
        last_wrap = c;
      end
      if (!vga_hs) hs_run++;
      if (!vga_vs) vs_run++;
      if (prev_hs && !vga_hs) begin
        n_tests++;
        if (fall_ref < 0 || c - fall_ref != 4) begin
          n_fail++; $display("FAIL hs_fall_delay: got %0d want 4", c - fall_ref);
        end
      end
      if (!prev_hs && vga_hs) begin
        n_tests++;
        if (hs_run != 2 * HSW) begin
          n_fail++; $display("FAIL hs_width: got %0d want %0d", hs_run, 2 * HSW);
        end
        hs_run = 0; n_hs_runs++;
      end
      if (!prev_vs && vga_vs) begin
        n_tests++;
        if (vs_run != 2 * VSW * HT) begin
          n_fail++; $display("FAIL vs_width: got %0d want %0d", vs_run, 2 * VSW * HT);
        end
        vs_run = 0; n_vs_runs++;
      end
      if (frame_start) begin
        n_tests++;
        if ((last_fs < 0) ? (c != 1) : (c - last_fs != 2 * FT)) begin
          n_fail++; $display("FAIL fs_period: got c=%0d last=%0d want period %0d", c, last_fs, 2 * FT);
        end
        last_fs = c;
      end
      prev_x  = int'(pix_x);
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end
    n_tests++; if (ce_bad != 0) begin n_fail++; $display("FAIL ce_phase: got %0d bad cycles want 0", ce_bad); end
    n_tests++; if (n_hs_runs != 2 * VT) begin n_fail++; $display("FAIL hs_runs: got %0d want %0d", n_hs_runs, 2 * VT); end
    n_tests++; if (n_vs_runs != 2) begin n_fail++; $display("FAIL vs_runs: got %0d want 2", n_vs_runs); end
  endtask

  task automatic test_solid();
    int n_full, n_other, n_lines;
    logic [11:0] prev;
    do_reset();
    fill_tab(2);
    release_reset();
    n_full = 0; n_other = 0; n_lines = 0; prev = 12'h0;
    for (int c = 0; c < 2 * FT + 4; c++) begin
      if (c > 0) tick();
      if ({vga_r, vga_g, vga_b} == 12'hFFF) n_full++;
      else if ({vga_r, vga_g, vga_b} != 12'h0) n_other++;
      if (prev == 12'h0 && {vga_r, vga_g, vga_b} == 12'hFFF) n_lines++;
      prev = {vga_r, vga_g, vga_b};
    end
    n_tests++; if (n_full != 2 * HA * VA) begin n_fail++; $display("FAIL solid_cycles: got %0d want %0d", n_full, 2 * HA * VA); end
    n_tests++; if (n_other != 0) begin n_fail++; $display("FAIL solid_other: got %0d want 0", n_other); end
    n_tests++; if (n_lines != VA) begin n_fail++; $display("FAIL solid_lines: got %0d want %0d", n_lines, VA); end
  endtask

  task automatic test_mid_reset();
    exp_t e, o;
    int q, target;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      fill_tab(3);
      release_reset();
      if (it == 0) q = $urandom_range(VA - 1) * HT + $urandom_range(HA - 1);
      else q = (VA + VFP + $urandom_range(VSW - 1)) * HT + HA + HFP + $urandom_range(HSW - 1);
      target = 2 * (q + 2) + $urandom_range(1);
      for (int c = 1; c <= target; c++) tick();
      e = model(target);
      n_tests++;
      if ({vga_hs, vga_vs, vga_r, vga_g, vga_b} !== {e.hs, e.vs, e.rgb}) begin
        n_fail++;
        $display("FAIL pre_reset_out: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                 vga_hs, vga_vs, {vga_r, vga_g, vga_b}, e.hs, e.vs, e.rgb);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({vga_hs, vga_vs, vga_r, vga_g, vga_b} !== {2'b11, 12'h0}) begin
        n_fail++;
        $display("FAIL mid_reset_out: got hs=%b vs=%b rgb=%h want hs=1 vs=1 rgb=000",
                 vga_hs, vga_vs, {vga_r, vga_g, vga_b});
      end
      n_tests++;
      if ({pix_x, pix_y, pix_req, pix_ce, frame_start} !== {20'h0, 3'b100}) begin
        n_fail++;
        $display("FAIL mid_reset_ctr: got x=%0d y=%0d req=%b ce=%b fs=%b want x=0 y=0 req=1 ce=0 fs=0",
                 pix_x, pix_y, pix_req, pix_ce, frame_start);
      end
      repeat (5) @(posedge clk);
      release_reset();
      for (int c = 0; c < 2 * FT + 4; c++) begin
        if (c > 0) tick();
        e = model(c);
        o = observed();
        n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL after_reset c=%0d got x=%0d y=%0d fs=%b hs=%b vs=%b rgb=%h want x=%0d y=%0d fs=%b hs=%b vs=%b rgb=%h",
                   c, o.x, o.y, o.fs, o.hs, o.vs, o.rgb, e.x, e.y, e.fs, e.hs, e.vs, e.rgb);
        end
      end
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int n_fs, c;
    exp_t e;
    do_reset();
    fill_tab(0);
    release_reset();
    n_fs = 0;
    for (c = 0; c < 6 * FT + 2; c++) begin
      if (c > 0) tick();
      e = model(c);
      if (e.fs) n_fs++;
    end
    // FRAME_CNT counts pulses whose cycle has already ended.
    e = model(c - 1);
    n_tests++;
    if (frame_cnt !== 16'(n_fs - (e.fs ? 1 : 0))) begin
      n_fail++; $display("FAIL fcnt_count: got %0d want %0d", frame_cnt, n_fs - (e.fs ? 1 : 0));
    end
    while (!model(c).fs) begin
      tick();
      c++;
    end
    // Cycle c is the FRAME_START cycle; preload just before its update edge.
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    tick();
    n_tests++;
    if (frame_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL fcnt_wrap: got %h want 0000", frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frames(2, 0);
    test_frames(1, 1);
    test_sync();
    test_solid();
    test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16; H_SYNC, 96; H_BP, 48; horizontal porch/sync widths in pixels (line total 800).
REQ-003 Parameter V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33; vertical widths in lines (frame total 525).
REQ-004 CLOCK_50  in  1  system clock, all logic on rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 PIX_R, PIX_G, PIX_B  in  4 each  renderer colour for the coordinate presented on the previous pixel tick.
REQ-007 PIX_X  out  10  current horizontal count (0..799).
REQ-008 PIX_Y  out  10  current vertical count (0..524).
REQ-009 PIX_REQ  out  1  high when (PIX_X, PIX_Y) lies in the visible area.
REQ-010 PIX_CE  out  1  pixel-tick enable, one CLOCK_50 cycle in every two.
REQ-011 FRAME_START  out  1  one-cycle pulse at the tick where counters are (0,0).
REQ-012 VGA_HS, VGA_VS  out  1 each  active-low syncs; VGA_R, VGA_G, VGA_B  out  4 each  colour.

Function
REQ-013 PIX_CE toggles every CLOCK_50 cycle; low in the first cycle after reset release (25 MHz tick rate).
REQ-014 Counters update only on cycles with PIX_CE high; hcnt 0..799 wraps to 0; vcnt increments when hcnt wraps, 0..524 wraps to 0.
REQ-015 PIX_X/PIX_Y are the registered counters; PIX_REQ = (hcnt < H_ACTIVE) and (vcnt < V_ACTIVE), decoded from registered counters.
REQ-016 FRAME_START is high exactly in the PIX_CE cycle where hcnt = 0 and vcnt = 0; low otherwise.
REQ-017 Stage 1 (on PIX_CE): registers hsync_n = not(656 <= hcnt <= 751), vsync_n = not(490 <= vcnt <= 491), active = PIX_REQ.
REQ-018 Stage 2 (on PIX_CE): VGA_HS/VGA_VS take stage-1 syncs; VGA_R/G/B take PIX_R/G/B when stage-1 active, else 0.
REQ-019 Total latency from counter value to matching VGA output is two pixel ticks for syncs and colour alike; syncs and colour stay mutually aligned.
REQ-020 Colour outputs are 0 for every pixel outside the visible area regardless of PIX_R/G/B.
REQ-021 Simultaneous hcnt and vcnt wrap (799, 524) proceeds to (0,0) in a single tick with FRAME_START asserted there.
REQ-022 Outputs change only on PIX_CE cycles; between ticks all outputs hold.

Reset
REQ-023 RESET_N low asynchronously forces hcnt = 0, vcnt = 0, PIX_CE phase = 0, both pipeline stages to HS = 1, VS = 1, active = 0, VGA_R/G/B = 0.
REQ-024 While RESET_N is low: PIX_X = 0, PIX_Y = 0, PIX_REQ = 1, PIX_CE = 0, FRAME_START = 0.
REQ-025 Reset asserted mid-frame aborts the frame; after release timing restarts at (0,0) with FRAME_START on the first PIX_CE cycle.

Configuration
REQ-026 Macro VGA_FRAME_CNT_EN defined: adds output FRAME_CNT (16 bits), reset 0, incremented in the FRAME_START cycle, wrapping 0xFFFF -> 0x0000.
REQ-027 Macro VGA_FRAME_CNT_EN undefined: FRAME_CNT port and counter are absent; all other behaviour is identical.

Verification
REQ-028 Release reset, run 2 frames -> PIX_CE period 2 cycles; line period 1600 cycles; frame period 840000 cycles; FRAME_START every 840000 cycles.
REQ-029 Measure syncs -> VGA_HS low for 192 consecutive cycles per line, falling 4 cycles after hcnt reaches 656; VGA_VS low for 3200 cycles per frame.
REQ-030 PIX_R/G/B held at 4'hF -> VGA colour = 4'hF for exactly 640 ticks per line on 480 lines per frame, 0 elsewhere (307200 visible ticks).
REQ-031 Renderer echoes PIX_X[3:0] as PIX_R, registered on PIX_CE -> VGA_R sequence 0,1,2,... starting at the first visible output tick of each line.
REQ-032 Assert RESET_N low at (hcnt 300, vcnt 200) for 5 cycles -> outputs HS = 1, VS = 1, RGB = 0 immediately; FRAME_START on first PIX_CE after release.
REQ-033 With VGA_FRAME_CNT_EN, force FRAME_CNT to 0xFFFF -> next FRAME_START gives 0x0000.
